// File: rtl/prefix_reduce_pipe.sv
// prefix_reduce_pipe
//   Two-stage pipelined running-prefix reducer. LANES operands of DATA_W bits
//   are folded left to right with a per-transaction operator (AND, OR, XOR or
//   NAND-prefix), producing LANES-1 prefix results. Valid/ready handshakes on
//   both sides with full backpressure, plus a wrapping count of consumed results.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand vector valid
//   in_ready   out  block can accept operands this cycle
//   in_data    in   LANES*DATA_W, lane k at [k*DATA_W +: DATA_W]
//   in_mode    in   2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NAND-prefix
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  (LANES-1)*DATA_W, prefix j at [j*DATA_W +: DATA_W]
//   out_mode   out  mode that produced out_data
//   done_cnt   out  CNT_W count of consumed results (wraps)
module prefix_reduce_pipe #(
  parameter int DATA_W = 1,
  parameter int LANES  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_W-1:0]       in_data,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(LANES-1)*DATA_W-1:0]   out_data,
  output logic [1:0]                    out_mode,
  output logic [CNT_W-1:0]              done_cnt
);

  localparam int IN_W  = LANES * DATA_W;
  localparam int OUT_W = (LANES - 1) * DATA_W;

  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  // Running fold across lanes. NAND-prefix chains with AND and inverts only
  // the emitted value, so the accumulator itself is never inverted.
  function automatic logic [OUT_W-1:0] prefix_f(input logic [IN_W-1:0] x,
                                                input logic [1:0]      mode);
    logic [DATA_W-1:0] acc;
    logic [OUT_W-1:0]  res;
    acc = x[0 +: DATA_W];
    res = '0;
    for (int j = 0; j < LANES - 1; j++) begin
      case (mode)
        MODE_OR:  acc = acc | x[(j+1)*DATA_W +: DATA_W];
        MODE_XOR: acc = acc ^ x[(j+1)*DATA_W +: DATA_W];
        default:  acc = acc & x[(j+1)*DATA_W +: DATA_W];
      endcase
      res[j*DATA_W +: DATA_W] = (mode == MODE_NAND) ? ~acc : acc;
    end
    return res;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [IN_W-1:0]  data_p1_q, data_p1_d;
  logic [1:0]       mode_p1_q, mode_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [OUT_W-1:0] data_p2_q, data_p2_d;
  logic [1:0]       mode_p2_q, mode_p2_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             s1_en, s2_en;

  // Each stage may advance when it is empty or its downstream is advancing,
  // which allows accept, move and emit in the same cycle.
  assign s2_en    = !vld_p2_q || out_ready;
  assign s1_en    = !vld_p1_q || s2_en;
  assign in_ready = s1_en;

  always_comb begin
    vld_p1_d   = vld_p1_q;
    data_p1_d  = data_p1_q;
    mode_p1_d  = mode_p1_q;
    vld_p2_d   = vld_p2_q;
    data_p2_d  = data_p2_q;
    mode_p2_d  = mode_p2_q;
    done_cnt_d = done_cnt_q;

    // ---- stage 1: operand capture ----
    if (s1_en) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        data_p1_d = in_data;
        mode_p1_d = in_mode;
      end
    end

    // ---- stage 2: prefix result ----
    if (s2_en) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d = prefix_f(data_p1_q, mode_p1_q);
        mode_p2_d = mode_p1_q;
      end
    end

    // ---- output handshake ----
    if (vld_p2_q && out_ready)
      done_cnt_d = done_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      data_p1_q  <= '0;
      mode_p1_q  <= '0;
      vld_p2_q   <= 1'b0;
      data_p2_q  <= '0;
      mode_p2_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      data_p1_q  <= data_p1_d;
      mode_p1_q  <= mode_p1_d;
      vld_p2_q   <= vld_p2_d;
      data_p2_q  <= data_p2_d;
      mode_p2_q  <= mode_p2_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_mode  = mode_p2_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_prefix_reduce_pipe.sv
// Bench for prefix_reduce_pipe: one default instance (DATA_W=1, LANES=4,
// CNT_W=8) and one wide instance (DATA_W=3, LANES=5, CNT_W=3) driven with the
// same handshake and mode, each with its own operand data.
module tb_prefix_reduce_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic [3:0]  in_data_a;
  logic [14:0] in_data_b;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [2:0]  out_data_a;
  logic [11:0] out_data_b;
  logic [1:0]  out_mode_a, out_mode_b;
  logic [7:0]  done_cnt_a;
  logic [2:0]  done_cnt_b;

  prefix_reduce_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_mode(in_mode), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_mode(out_mode_a),
    .done_cnt(done_cnt_a)
  );

  prefix_reduce_pipe #(.DATA_W(3), .LANES(5), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_mode(in_mode), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_mode(out_mode_b),
    .done_cnt(done_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  da;
    logic [11:0] db;
    logic [1:0]  m;
    int          acc_cyc;
  } item_t;

  item_t       q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_emit   = 0;
  int          cnt      = 0;
  bit          accepted;
  logic [2:0]  last_a;
  logic [1:0]  last_m;

  // Prefix j of bit b is the reduction over lanes 0..j+1, computed by
  // counting ones in that set of bits.
  function automatic logic [31:0] ref_prefix(input logic [63:0] x, input int dw,
                                             input int lanes, input logic [1:0] m);
    logic [31:0] r;
    int ones;
    logic bitv;
    r = '0;
    for (int j = 0; j < lanes - 1; j++) begin
      for (int b = 0; b < dw; b++) begin
        ones = 0;
        for (int k = 0; k <= j + 1; k++) ones += int'(x[k*dw+b]);
        case (m)
          2'd0:    bitv = (ones == j + 2);
          2'd1:    bitv = (ones > 0);
          2'd2:    bitv = (ones % 2 == 1);
          default: bitv = !(ones == j + 2);
        endcase
        r[j*dw+b] = bitv;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check everything at the falling edge, update the model with
  // what the handshakes will do at the next rising edge, then advance.
  task automatic tick();
    bit exp_ready, exp_valid;
    item_t it;
    @(negedge clk);
    exp_ready = (q.size() < 2) || out_ready;
    exp_valid = (q.size() > 0) && (cyc >= q[0].acc_cyc + 2);
    chk("in_ready_a", in_ready_a, exp_ready);
    chk("in_ready_b", in_ready_b, exp_ready);
    chk("out_valid_a", out_valid_a, exp_valid);
    chk("out_valid_b", out_valid_b, exp_valid);
    chk("done_cnt_a", done_cnt_a, cnt % 256);
    chk("done_cnt_b", done_cnt_b, cnt % 8);
    if (exp_valid) begin
      chk("out_data_a", out_data_a, q[0].da);
      chk("out_data_b", out_data_b, q[0].db);
      chk("out_mode_a", out_mode_a, q[0].m);
      chk("out_mode_b", out_mode_b, q[0].m);
    end
    if (exp_valid && out_ready) begin
      last_a = q[0].da;
      last_m = q[0].m;
      void'(q.pop_front());
      cnt++;
      n_emit++;
    end
    accepted = in_valid && exp_ready;
    if (accepted) begin
      it.da = 3'(ref_prefix(64'(in_data_a), 1, 4, in_mode));
      it.db = 12'(ref_prefix(64'(in_data_b), 3, 5, in_mode));
      it.m  = in_mode;
      it.acc_cyc = cyc;
      q.push_back(it);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [3:0] da, input logic [14:0] db, input logic [1:0] m);
    in_valid  = 1'b1;
    in_data_a = da;
    in_data_b = db;
    in_mode   = m;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid_a", out_valid_a, 0);
    chk("rst_out_valid_b", out_valid_b, 0);
    chk("rst_done_cnt_a", done_cnt_a, 0);
    chk("rst_done_cnt_b", done_cnt_b, 0);
    chk("rst_out_data_a", out_data_a, 0);
    chk("rst_out_mode_a", out_mode_a, 0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready_a", in_ready_a, 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    logic [2:0] held;
    int t0, e0;
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; out_ready = 1'b1;
    in_data_a = '0; in_data_b = '0;
    #2;
    chk("init_out_valid", out_valid_a, 0);
    chk("init_done_cnt", done_cnt_a, 0);
    chk("init_out_data", out_data_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("init_in_ready", in_ready_a, 1);

    // Directed AND vectors
    send(4'b1111, 15'($urandom), 2'b00); drain();
    chk("and_1111", last_a, 3'b111);
    send(4'b1011, 15'($urandom), 2'b00); drain();
    chk("and_1011", last_a, 3'b001);

    // Modes on x0..x3 = 1,0,1,1
    send(4'b1101, 15'($urandom), 2'b01); drain();
    chk("or_1101", last_a, 3'b111);   chk("or_mode", last_m, 2'b01);
    send(4'b1101, 15'($urandom), 2'b10); drain();
    chk("xor_1101", last_a, 3'b101);  chk("xor_mode", last_m, 2'b10);
    send(4'b1101, 15'($urandom), 2'b11); drain();
    chk("nand_1101", last_a, 3'b111); chk("nand_mode", last_m, 2'b11);

    // Back-to-back stream of 10 at full throughput
    do_reset();
    out_ready = 1'b1;
    t0 = cyc; e0 = n_emit;
    for (int i = 0; i < 10; i++) send(4'($urandom), 15'($urandom), 2'($urandom));
    chk("stream_accept_cycles", cyc - t0, 10);
    drain();
    chk("stream_emits", n_emit - e0, 10);
    chk("stream_done_cnt", done_cnt_a, 10);

    // Stall for 5 cycles with both stages full
    out_ready = 1'b0;
    e0 = n_emit;
    send(4'($urandom), 15'($urandom), 2'($urandom));
    send(4'($urandom), 15'($urandom), 2'($urandom));
    in_valid = 1'b1; in_data_a = 4'($urandom); in_data_b = 15'($urandom);
    in_mode = 2'($urandom);
    #1 held = out_data_a;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_accept", accepted, 0);
      chk("stall_in_ready", in_ready_a, 0);
      chk("stall_hold", out_data_a, held);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (accepted) break;
    end
    chk("stall_release_accept", accepted, 1);
    drain();
    chk("stall_emits", n_emit - e0, 3);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1; in_data_a = 4'($urandom); in_data_b = 15'($urandom);
        in_mode = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (accepted) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    drain();

    // Reset with both stages occupied, then a cold transaction
    out_ready = 1'b0;
    send(4'($urandom), 15'($urandom), 2'($urandom));
    send(4'($urandom), 15'($urandom), 2'($urandom));
    do_reset();
    out_ready = 1'b1;
    send(4'b1101, 15'($urandom), 2'b01);
    tick();
    chk("post_rst_valid", out_valid_a, 1);
    chk("post_rst_data", out_data_a, 3'b111);
    drain();
    chk("post_rst_cnt", done_cnt_a, 1);

    // Counter wrap on the 3-bit instance
    do_reset();
    for (int i = 0; i < 9; i++) send(4'($urandom), 15'($urandom), 2'($urandom));
    drain();
    chk("wrap_cnt_b", done_cnt_b, 1);
    chk("wrap_cnt_a", done_cnt_a, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prefix_reduce_pipe.md
Name: prefix_reduce_pipe

Overview:
- Parametrised, pipelined successor to the cascaded-AND chain.
- Takes LANES operands of DATA_W bits and produces every running prefix: out[0]=op(x0,x1), out[1]=op(out[0],x2), and so on.
- Operation is selectable per transaction: AND, OR, XOR or NAND-prefix.
- Two-stage registered datapath with valid/ready handshakes and backpressure, plus a transaction counter. Sits between the switch/button input capture and the LED/7-seg display logic in the lab top level.

Parameters:
- DATA_W, 1, bit width of each operand lane.
- LANES, 4, number of operand lanes; must be >= 2. Produces LANES-1 prefix results.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept operands this cycle.
- in_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W].
- in_mode  in  2  00 AND, 01 OR, 10 XOR, 11 NAND-prefix.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  (LANES-1)*DATA_W  prefix j at bits [j*DATA_W +: DATA_W].
- out_mode  out  2  mode that produced out_data.
- done_cnt  out  CNT_W  count of results consumed.

Behaviour:
- Reset (async, rst=1) clears s1_valid, s2_valid, all data/mode registers, out_data, out_mode and done_cnt to 0. in_ready reads 1 once reset deasserts.
- Pipeline stages:
  - S1 registers in_data and in_mode.
  - S2 registers the prefix result computed combinationally from S1.
  - out_data and out_mode come straight from the S2 registers.
- Prefix arithmetic, bitwise per lane, with p0 = x0 op x1 and pj = p(j-1) op x(j+1):
  - AND, OR, XOR: out_data[j] = pj.
  - NAND-prefix: the chain is computed with AND and each output is inverted, out_data[j] = ~pj. Inverted values are not fed forward.
- Advance rules:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en, combinational from out_ready and the valid flags.
- Accept: in_valid & in_ready at edge T loads S1, and s1_valid=1 after T.
- Move: s1_valid & s2_en at an edge loads S2 and sets s2_valid=1. If s1_valid=0 and s2_en=1, s2_valid clears.
- Emit: out_valid = s2_valid.
- Latency: accept at edge T gives out_valid high after edge T+1 when there is no stall. Throughput is one result per cycle with out_ready held high.
- Stall (out_ready=0 with s2_valid=1):
  - S2 holds, and out_data and out_mode stay stable.
  - S1 holds if it is valid, so in_ready drops.
  - If S1 is empty, one more input is still accepted into S1.
- No data loss or duplication under any out_ready pattern.
- Mode travels with its data. Changing in_mode between transactions never alters an in-flight result.
- done_cnt increments by 1 on every out_valid & out_ready edge and wraps from 2^CNT_W-1 to 0.
- Simultaneous accept, move and emit in one cycle is legal and required for full throughput.
- Reset asserted mid-operation immediately discards in-flight data. The first transaction after reset behaves as from cold.
- in_valid while in_ready=0 has no effect. The source must hold in_data and in_mode until accepted.

Test Plan:
- Defaults, AND, in_data=4'b1111 -> out_data=3'b111 two cycles after accept. Then in_data=4'b1011 (x2=0) -> out_data=3'b001.
- Modes on DATA_W=1, LANES=4, x0..x3=1,0,1,1:
  - OR -> 3'b111.
  - XOR -> prefixes 1,0,1 give out_data=3'b101.
  - NAND-prefix -> 3'b111.
  - out_mode matches each.
- Back-to-back stream of 10 vectors, out_ready=1 -> 10 consecutive out_valid cycles in order, done_cnt=10.
- out_ready=0 for 5 cycles while streaming:
  - in_ready drops after two accepts.
  - out_data is held stable.
  - On release, results emerge in order with none lost.
- CNT_W=3, 9 consumed results -> done_cnt reads 1 (wrap).
- rst pulse while S1 and S2 are valid -> out_valid=0 and done_cnt=0 immediately. The next input yields a correct result after 2 cycles.
